// File: rtl/trg_sched.sv
// Trigger scheduler: prescales enabled group matches, issues a tagged trigger,
// then sequences dead time and busy release (with timeout), counting lost events.
module trg_sched #(
  parameter int          NGRP    = 5,
  parameter logic [23:0] TMO_CYC = 24'd15000,
  parameter int          CNT_W   = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              run_en_in,
  input  logic [NGRP-1:0]   grp_match_in,
  input  logic [NGRP-1:0]   grp_oe_in,
  input  logic [6*NGRP-1:0] grp_div_in,
  input  logic [1:0]        busy_in,
  input  logic [7:0]        dead_time_in,
  output logic              trg_out,
  output logic [NGRP-1:0]   trg_tag_out,
  output logic              busy_out,
  output logic [1:0]        state_out,
  output logic [CNT_W-1:0]  trg_cnt_out,
  output logic [CNT_W-1:0]  lost_cnt_out,
  output logic [CNT_W-1:0]  tmo_cnt_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRIG = 2'd1,
    S_DEAD = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t                 state;
  logic [NGRP-1:0][5:0]   pc;
  logic [NGRP-1:0][5:0]   pc_nxt;
  logic [NGRP-1:0]        en;
  logic [NGRP-1:0]        pass;
  logic [7:0]             dcnt;
  logic [23:0]            tcnt;
  logic                   lost_hit;

  function automatic logic [5:0] div_eff(input logic [5:0] d);
    return (d == 6'd0) ? 6'd1 : d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Prescaler decision: only advances while idle and running
  always_comb begin
    en     = grp_match_in & grp_oe_in;
    pass   = '0;
    pc_nxt = pc;
    for (int g = 0; g < NGRP; g++) begin
      if (!run_en_in) begin
        pc_nxt[g] = 6'd0;
      end else if (state == S_IDLE && en[g]) begin
        if (pc[g] >= div_eff(grp_div_in[6*g +: 6]) - 6'd1) begin
          pass[g]   = 1'b1;
          pc_nxt[g] = 6'd0;
        end else begin
          pc_nxt[g] = pc[g] + 6'd1;
        end
      end
    end
  end

  assign lost_hit  = (state != S_IDLE) && run_en_in && (|en);
  assign busy_out  = (state != S_IDLE) || !run_en_in;
  assign state_out = state;

  // Sequencer and statistics
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= S_IDLE;
      pc           <= '0;
      dcnt         <= 8'd0;
      tcnt         <= 24'd0;
      trg_out      <= 1'b0;
      trg_tag_out  <= '0;
      trg_cnt_out  <= '0;
      lost_cnt_out <= '0;
      tmo_cnt_out  <= '0;
    end else begin
      pc      <= pc_nxt;
      trg_out <= 1'b0;
      if (lost_hit) lost_cnt_out <= sat_inc(lost_cnt_out);
      case (state)
        S_IDLE: begin
          if (|pass) begin
            state       <= S_TRIG;
            trg_out     <= 1'b1;
            trg_tag_out <= pass;
          end
        end
        S_TRIG: begin
          trg_cnt_out <= sat_inc(trg_cnt_out);
          tcnt        <= 24'd0;
          if (dead_time_in == 8'd0) begin
            state <= S_WAIT;
          end else begin
            dcnt  <= dead_time_in;
            state <= S_DEAD;
          end
        end
        S_DEAD: begin
          dcnt <= dcnt - 8'd1;
          if (dcnt == 8'd1) begin
            state <= S_WAIT;
            tcnt  <= 24'd0;
          end
        end
        S_WAIT: begin
          if (busy_in == 2'b00) begin
            state <= S_IDLE;
          end else if (tcnt == TMO_CYC - 24'd1) begin
            state       <= S_IDLE;
            tmo_cnt_out <= sat_inc(tmo_cnt_out);
          end else begin
            tcnt <= tcnt + 24'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trg_sched.sv
// Self-checking bench for trg_sched: directed scenarios plus random traffic,
// compared every cycle against a timeline-based reference model.
module tb_trg_sched;

  localparam int NG   = 5;
  localparam int TMO  = 15000;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic           clk = 1'b0;
  logic           rst;
  logic           run_en;
  logic [NG-1:0]  match;
  logic [NG-1:0]  oe;
  logic [6*NG-1:0] div;
  logic [1:0]     busy;
  logic [7:0]     dead;
  logic           trg_out;
  logic [NG-1:0]  trg_tag;
  logic           busy_o;
  logic [1:0]     state_o;
  logic [CW-1:0]  trg_cnt;
  logic [CW-1:0]  lost_cnt;
  logic [CW-1:0]  tmo_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: idle flag plus cycles since trigger and cycles spent waiting
  bit m_idle;
  bit m_pulse;
  int m_age, m_dead, m_w;
  int m_pc[NG];
  int m_tag, m_trg, m_lost, m_tmo;

  trg_sched #(.NGRP(NG), .TMO_CYC(24'd15000), .CNT_W(CW)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .run_en_in    (run_en),
    .grp_match_in (match),
    .grp_oe_in    (oe),
    .grp_div_in   (div),
    .busy_in      (busy),
    .dead_time_in (dead),
    .trg_out      (trg_out),
    .trg_tag_out  (trg_tag),
    .busy_out     (busy_o),
    .state_out    (state_o),
    .trg_cnt_out  (trg_cnt),
    .lost_cnt_out (lost_cnt),
    .tmo_cnt_out  (tmo_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x < CMAX) ? x + 1 : x;
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_pulse = 1'b0;
    m_age = 0; m_dead = 0; m_w = 0;
    m_tag = 0; m_trg = 0; m_lost = 0; m_tmo = 0;
    for (int g = 0; g < NG; g++) m_pc[g] = 0;
  endtask

  task automatic model_edge();
    logic [NG-1:0] en;
    int pass;
    en = match & oe;
    m_pulse = 1'b0;
    if (!m_idle && run_en && (en != '0)) m_lost = sat(m_lost);
    if (m_idle) begin
      if (run_en) begin
        pass = 0;
        for (int g = 0; g < NG; g++) begin
          if (en[g]) begin
            int d;
            d = int'(div[6*g +: 6]);
            if (d == 0) d = 1;
            if (m_pc[g] + 1 >= d) begin
              pass = pass | (1 << g);
              m_pc[g] = 0;
            end else begin
              m_pc[g] = m_pc[g] + 1;
            end
          end
        end
        if (pass != 0) begin
          m_idle = 1'b0; m_age = 0; m_tag = pass; m_pulse = 1'b1;
        end
      end
    end else if (m_age == 0) begin
      m_trg = sat(m_trg); m_dead = int'(dead); m_age = 1; m_w = 0;
    end else if (m_age <= m_dead) begin
      m_age++;
    end else if (busy == 2'b00) begin
      m_idle = 1'b1;
    end else begin
      m_w++;
      if (m_w == TMO) begin
        m_idle = 1'b1;
        m_tmo = sat(m_tmo);
      end
    end
    if (!run_en) for (int g = 0; g < NG; g++) m_pc[g] = 0;
  endtask

  task automatic check_all();
    int es;
    if (m_idle)             es = 0;
    else if (m_age == 0)    es = 1;
    else if (m_age <= m_dead) es = 2;
    else                    es = 3;
    chk("state",    32'(state_o),  32'(es));
    chk("trg_out",  32'(trg_out),  32'(m_pulse));
    chk("tag",      32'(trg_tag),  32'(m_tag));
    chk("busy_out", 32'(busy_o),   32'((!m_idle) || !run_en));
    chk("trg_cnt",  32'(trg_cnt),  32'(m_trg));
    chk("lost_cnt", 32'(lost_cnt), 32'(m_lost));
    chk("tmo_cnt",  32'(tmo_cnt),  32'(m_tmo));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic tick(input logic [NG-1:0] m);
    match = m;
    step();
    match = '0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) tick('0);
  endtask

  initial begin
    rst = 1'b1; run_en = 1'b0; match = '0; oe = '0; busy = 2'b00; dead = 8'd0;
    div = {NG{6'd1}};
    model_reset();
    #1;
    check_all();
    @(posedge clk); #1;
    check_all();
    chk("rst_busy", 32'(busy_o), 32'd1);
    #2 rst = 1'b0;

    // 1: single g0 pulse, dead time 5
    run_en = 1'b1; oe = 5'b00011; dead = 8'd5;
    idle_n(2);
    tick(5'b00001);
    chk("t1_tag", 32'(trg_tag), 32'h01);
    chk("t1_pulse", 32'(trg_out), 32'd1);
    idle_n(7);
    chk("t1_idle8", 32'(state_o), 32'd0);
    chk("t1_trgcnt", 32'(trg_cnt), 32'd1);

    // 2: g1 prescaled by 2
    oe = 5'b00010; div[11:6] = 6'd2;
    for (int p = 0; p < 6; p++) begin
      tick(5'b00010);
      idle_n(19);
    end
    chk("t2_trgcnt", 32'(trg_cnt), 32'd4);
    chk("t2_lost", 32'(lost_cnt), 32'd0);

    // 3: simultaneous groups, then a lost pulse during dead time
    oe = 5'b00011; div[11:6] = 6'd1;
    tick(5'b00011);
    chk("t3_tag", 32'(trg_tag), 32'h03);
    tick('0);
    tick(5'b00001);
    idle_n(10);
    chk("t3_lost", 32'(lost_cnt), 32'd1);
    chk("t3_trgcnt", 32'(trg_cnt), 32'd5);

    // 4: busy held to timeout, then released early
    busy = 2'b01;
    tick(5'b00001);
    idle_n(6 + TMO + 2);
    chk("t4_tmo", 32'(tmo_cnt), 32'd1);
    tick(5'b00001);
    idle_n(6 + 100);
    busy = 2'b00;
    idle_n(5);
    chk("t4_tmo_keep", 32'(tmo_cnt), 32'd1);
    chk("t4_trgcnt", 32'(trg_cnt), 32'd7);

    // 5: run enable dropped mid-sequence
    dead = 8'd20;
    tick(5'b00001);
    idle_n(3);
    run_en = 1'b0;
    idle_n(30);
    for (int i = 0; i < 4; i++) begin tick(5'b00011); idle_n(2); end
    chk("t5_trgcnt", 32'(trg_cnt), 32'd8);
    run_en = 1'b1;
    idle_n(1);
    tick(5'b00001);
    chk("t5_retrig", 32'(trg_out), 32'd1);
    idle_n(30);

    // 6: asynchronous reset while waiting on busy
    busy = 2'b01;
    tick(5'b00001);
    idle_n(30);
    chk("t6_inwait", 32'(state_o), 32'd3);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    check_all();
    rst = 1'b0; busy = 2'b00;
    tick(5'b00001);
    chk("t6_after", 32'(trg_out), 32'd1);
    idle_n(30);

    // Random traffic
    for (int blk = 0; blk < 60; blk++) begin
      oe     = NG'($urandom);
      for (int g = 0; g < NG; g++) div[6*g +: 6] = 6'($urandom_range(0, 3));
      dead   = 8'($urandom_range(0, 6));
      run_en = ($urandom_range(0, 7) != 0);
      for (int c = 0; c < 50; c++) begin
        if ($urandom_range(0, 3) == 0) busy = 2'($urandom);
        tick(NG'($urandom) & NG'($urandom));
      end
    end
    busy = 2'b00; run_en = 1'b1;
    idle_n(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
